// File: rtl/router_node_port.sv
// Router-side node link endpoint: 4-byte MSB-first RX reassembly and TX serialization, FIFO-buffered each way.
// Latency: RX byte3 at edge M -> rx_valid after M; TX push at edge N -> put_to_node after N+1 (free_from_node=1).
// Backpressure: free_to_node gated by RX FIFO space, TX waits on free_from_node, tx_ready=TX FIFO not full; ROUTER_NODE_PORT_STATS_EN adds packet counters.

module router_node_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             wr_en, rd_en;

  assign wr_en = push && (count < CW'(DEPTH));
  assign rd_en = pop && (count != '0);
  assign head  = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end
endmodule

module router_node_port #(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        put_from_node,
  input  logic [7:0]  payload_from_node,
  output logic        free_to_node,
  output logic        put_to_node,
  output logic [7:0]  payload_to_node,
  input  logic        free_from_node,
  output logic [31:0] rx_pkt,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [31:0] tx_pkt,
  input  logic        tx_valid,
`ifdef ROUTER_NODE_PORT_STATS_EN
  output logic        tx_ready,
  output logic [15:0] rx_pkt_cnt,
  output logic [15:0] tx_pkt_cnt
`else
  output logic        tx_ready
`endif
);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);

  typedef enum logic [1:0] {R_IDLE, R_B1, R_B2, R_B3} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_state_t;

  // ---------------- RX: node -> crossbar ----------------
  rx_state_t        rx_state, rx_state_d;
  logic [7:0]       rx_b0, rx_b1, rx_b2, rx_b0_d, rx_b1_d, rx_b2_d;
  logic             rx_push, rx_pop, free_d;
  logic [RX_CW-1:0] rx_count, rx_count_d;

  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_valid && rx_ready;

  router_node_port_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (rx_push),
    .push_dat ({rx_b0, rx_b1, rx_b2, payload_from_node}),
    .pop      (rx_pop),
    .head     (rx_pkt),
    .count    (rx_count)
  );

  always_comb begin
    rx_state_d = rx_state;
    rx_b0_d    = rx_b0;
    rx_b1_d    = rx_b1;
    rx_b2_d    = rx_b2;
    rx_push    = 1'b0;
    case (rx_state)
      R_IDLE: if (put_from_node) begin rx_b0_d = payload_from_node; rx_state_d = R_B1; end
      R_B1:   if (put_from_node) begin rx_b1_d = payload_from_node; rx_state_d = R_B2; end
      R_B2:   if (put_from_node) begin rx_b2_d = payload_from_node; rx_state_d = R_B3; end
      R_B3:   if (put_from_node) begin rx_push = 1'b1; rx_state_d = R_IDLE; end
      default: rx_state_d = R_IDLE;
    endcase
    // free is registered from next-cycle state so it tracks the FSM without a cycle of lag
    rx_count_d = rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
    free_d     = (rx_state_d == R_IDLE) && (rx_count_d < RX_CW'(RX_DEPTH));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state     <= R_IDLE;
      rx_b0        <= '0;
      rx_b1        <= '0;
      rx_b2        <= '0;
      free_to_node <= 1'b1;
    end else begin
      rx_state     <= rx_state_d;
      rx_b0        <= rx_b0_d;
      rx_b1        <= rx_b1_d;
      rx_b2        <= rx_b2_d;
      free_to_node <= free_d;
    end
  end

  // ---------------- TX: crossbar -> node ----------------
  tx_state_t        tx_state, tx_state_d;
  logic [1:0]       tx_cnt, tx_cnt_d;
  logic [23:0]      tx_shift, tx_shift_d;
  logic             put_d, tx_push, tx_pop;
  logic [7:0]       payload_d;
  logic [31:0]      tx_head;
  logic [TX_CW-1:0] tx_count;

  assign tx_ready = (tx_count < TX_CW'(TX_DEPTH));
  assign tx_push  = tx_valid && tx_ready;

  router_node_port_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (tx_push),
    .push_dat (tx_pkt),
    .pop      (tx_pop),
    .head     (tx_head),
    .count    (tx_count)
  );

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_shift_d = tx_shift;
    put_d      = 1'b0;
    payload_d  = payload_to_node;
    tx_pop     = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if ((tx_count != '0) && free_from_node) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head[23:0];
          put_d      = 1'b1;
          payload_d  = tx_head[31:24];
          tx_cnt_d   = 2'd1;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        put_d      = 1'b1;
        payload_d  = tx_shift[23:16];
        tx_shift_d = {tx_shift[15:0], 8'h00};
        tx_cnt_d   = tx_cnt + 2'd1;
        if (tx_cnt == 2'd3) tx_state_d = T_GAP;
      end
      T_GAP:   tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state        <= T_IDLE;
      tx_cnt          <= '0;
      tx_shift        <= '0;
      put_to_node     <= 1'b0;
      payload_to_node <= '0;
    end else begin
      tx_state        <= tx_state_d;
      tx_cnt          <= tx_cnt_d;
      tx_shift        <= tx_shift_d;
      put_to_node     <= put_d;
      payload_to_node <= payload_d;
    end
  end

`ifdef ROUTER_NODE_PORT_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_pkt_cnt <= '0;
      tx_pkt_cnt <= '0;
    end else begin
      if (rx_push) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      if ((tx_state == T_SEND) && (tx_cnt == 2'd3)) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/router_node_port.md
Name: router_node_port

Overview:
- Router-side endpoint of the byte-serial node/router link.
- Receives 32-bit packets from a node as 4 bytes (put/free handshake), reassembles them, and buffers them in an RX FIFO toward the router crossbar.
- Accepts 32-bit packets from the crossbar into a TX FIFO and serializes them to the node as 4 bytes using the same handshake.
- Byte order is MSB first: [31:24], [23:16], [15:8], [7:0].

Parameters:
- RX_DEPTH, 4, RX FIFO depth in packets (>=1).
- TX_DEPTH, 4, TX FIFO depth in packets (>=1).

Ports:
- clock  input  1  system clock, posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- put_from_node  input  1  node drives a valid byte this cycle.
- payload_from_node  input  8  byte from node.
- free_to_node  output  1  port can accept one full packet from node.
- put_to_node  output  1  port drives a valid byte this cycle.
- payload_to_node  output  8  byte to node.
- free_from_node  input  1  node can accept one full packet.
- rx_pkt  output  32  head of RX FIFO (combinational).
- rx_valid  output  1  RX FIFO non-empty.
- rx_ready  input  1  crossbar consumes rx_pkt at this edge.
- tx_pkt  input  32  packet from crossbar.
- tx_valid  input  1  tx_pkt valid.
- tx_ready  output  1  TX FIFO not full.

Behaviour:
- Reset (asynchronous, active-low) values:
  - free_to_node=1, put_to_node=0, payload_to_node=0, rx_valid=0, tx_ready=1.
  - Both FIFOs empty; both FSMs IDLE.
  - A partial packet in either direction is discarded, with no residue after reset release.
- RX FSM states: R_IDLE, R_B1, R_B2, R_B3.
  - free_to_node is registered, and is 1 only when the FSM is in R_IDLE and rx_count < RX_DEPTH.
  - R_IDLE with put_from_node=1: capture byte into [31:24], go to R_B1.
  - R_B1 and R_B2: capture byte into [23:16] and [15:8] respectively when put_from_node=1, then advance. If put=0 the FSM holds and captures nothing; this is a protocol gap, not an error.
  - R_B3 with put_from_node=1: write {b0,b1,b2,payload_from_node} into the RX FIFO at this edge, return to R_IDLE. rx_valid is high the following cycle.
  - free_to_node falls in the cycle after byte0 is captured. It rises again the cycle after return to R_IDLE if space remains.
  - Overflow is impossible by construction: free is gated by count, and count never increases during assembly.
- RX FIFO:
  - Pop occurs on rx_valid && rx_ready.
  - A simultaneous push and pop leaves the count unchanged and preserves order.
  - Pop when empty is ignored.
- TX FIFO:
  - Push occurs on tx_valid && tx_ready.
  - tx_ready = count < TX_DEPTH.
  - Push when full is ignored.
  - A simultaneous push and pop is allowed.
- TX FSM states: T_IDLE, T_SEND, T_GAP.
  - T_IDLE with TX FIFO non-empty and free_from_node=1 at the edge: pop the head into a shift register, drive put_to_node=1 and payload_to_node=[31:24], go to T_SEND with byte counter 1.
  - T_SEND: drive bytes 1, 2, 3 on the next three cycles. put_to_node is high for exactly 4 consecutive cycles.
  - free_from_node is ignored once sending has started.
  - After byte3 the FSM goes to T_GAP: put_to_node=0 for one cycle, then T_IDLE. This guarantees at least one idle cycle between packets.
  - free_from_node=0 in T_IDLE causes the FSM to wait indefinitely with no timeout.
- Latency:
  - TX: push at edge N, put_to_node high from edge N+1 if free_from_node=1.
  - RX: byte3 sampled at edge M, rx_valid high after edge M.
- All node-side outputs are registered.
- rx_pkt is only meaningful when rx_valid=1.
- RX and TX paths are fully independent and may run concurrently.

Optional Feature:
- Macro: ROUTER_NODE_PORT_STATS_EN.
- When defined, two extra outputs are added:
  - rx_pkt_cnt (16 bits): increments on every RX FIFO push.
  - tx_pkt_cnt (16 bits): increments when the TX FSM sends byte3.
- Both counters wrap from 0xFFFF to 0 and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- RX single packet: put_from_node high 4 cycles with bytes 0xDE, 0xAD, 0xBE, 0xEF -> rx_valid high the cycle after the 4th byte, rx_pkt=0xDEADBEEF, and free_to_node low during assembly, high after.
- RX fill/backpressure: rx_ready=0, send 4 packets 0x11111111..0x44444444 -> free_to_node stays 0 after the 4th. Pulse rx_ready once -> 0x11111111 popped, free_to_node returns to 1.
- TX single: push tx_pkt=0xCAFEF00D with free_from_node=1 -> put_to_node high exactly 4 cycles with 0xCA, 0xFE, 0xF0, 0x0D, followed by at least 1 low cycle.
- TX blocked: push 2 packets with free_from_node=0 for 10 cycles -> put_to_node stays 0. Raise free -> both packets are sent in order, separated by a 1-cycle gap, and tx_ready=1 throughout (count 2 < 4).
- RX gap + reset: send bytes 0x01, 0x02, drop put 3 cycles, then send 0x03, 0x04 -> rx_pkt=0x01020304. Repeat, asserting reset_n=0 after byte 2 -> no packet appears and all outputs are at reset values.
- Concurrent: simultaneous RX of 0xA5A5A5A5 and TX of 0x5A5A5A5A -> both complete with correct data and identical latencies.
